// File: rtl/seq_multiplier.sv
// seq_multiplier: radix-2 shift-add MUL/MULH/MULHSU/MULHU with Start/Busy/Done; define SEQ_MULTIPLIER_EARLY_EXIT_EN to skip trailing zero multiplier bits
module seq_multiplier #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] Multiplicand,
  input  logic [WIDTH-1:0] Multiplier,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Product
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, MULTIPLY, FINISH} state_t;
  state_t             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic               neg_q, neg_d, done_q, done_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d, product_q, product_d;
  logic [2*WIDTH:0]   acc_q, acc_d;
  logic               a_s, b_s;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] p;
`ifdef SEQ_MULTIPLIER_EARLY_EXIT_EN
  logic               rest_zero;
`endif
  assign Busy    = state_q != IDLE;
  assign Done    = done_q;
  assign Product = product_q;
  // next-state: latch magnitudes on Start, add/shift per step, sign-fix and select half on FINISH
  always_comb begin
    a_s       = (Op == 2'b01 || Op == 2'b10) && Multiplicand[WIDTH-1];
    b_s       = Op == 2'b01 && Multiplier[WIDTH-1];
    a_mag     = a_s ? -Multiplicand : Multiplicand;
    b_mag     = b_s ? -Multiplier : Multiplier;
    sum       = acc_q[2*WIDTH:WIDTH] + (acc_q[0] ? {1'b0, a_q} : '0);
    p         = neg_q ? -acc_q[2*WIDTH-1:0] : acc_q[2*WIDTH-1:0];
`ifdef SEQ_MULTIPLIER_EARLY_EXIT_EN
    rest_zero = (acc_q[WIDTH-1:0] & ~({WIDTH{1'b1}} << cnt_q)) == '0;
`endif
    state_d   = state_q;
    op_d      = op_q;
    neg_d     = neg_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    acc_d     = acc_q;
    product_d = product_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: if (Start) begin
        op_d    = Op;
        neg_d   = a_s ^ b_s;
        a_d     = a_mag;
        acc_d   = {{(WIDTH+1){1'b0}}, b_mag};
        cnt_d   = CW'(WIDTH);
        state_d = MULTIPLY;
      end
      MULTIPLY: begin
        acc_d   = {1'b0, sum, acc_q[WIDTH-1:1]};
        cnt_d   = cnt_q - 1'b1;
        state_d = cnt_q == CW'(1) ? FINISH : MULTIPLY;
`ifdef SEQ_MULTIPLIER_EARLY_EXIT_EN
        if (rest_zero) begin
          acc_d   = acc_q >> cnt_q;
          cnt_d   = '0;
          state_d = FINISH;
        end
`endif
      end
      FINISH: begin
        product_d = op_q == 2'b00 ? p[WIDTH-1:0] : p[2*WIDTH-1:WIDTH];
        done_d    = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and registered outputs; reset aborts any operation immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      op_q      <= '0;
      neg_q     <= 1'b0;
      cnt_q     <= '0;
      a_q       <= '0;
      acc_q     <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      neg_q     <= neg_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      acc_q     <= acc_d;
      product_q <= product_d;
      done_q    <= done_d;
    end
  end
endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: table-driven and scoreboard checks of seq_multiplier at WIDTH=64
module tb_seq_multiplier;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        Start = 1'b0;
  logic [1:0]  Op = '0;
  logic [63:0] Multiplicand = '0;
  logic [63:0] Multiplier = '0;
  logic        Busy, Done;
  logic [63:0] Product;
  int          checks = 0;
  int          errors = 0;
  logic [63:0] sb[$];
  logic [63:0] last_exp = '0;
  typedef struct {
    logic [1:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
  } vec_t;
  vec_t tbl[9];

  seq_multiplier #(.WIDTH(64)) dut (
    .clk(clk), .reset(reset), .Start(Start), .Op(Op),
    .Multiplicand(Multiplicand), .Multiplier(Multiplier),
    .Busy(Busy), .Done(Done), .Product(Product)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [127:0] ae, be, pr;
    ae = (op == 2'b01 || op == 2'b10) ? {{64{a[63]}}, a} : {64'b0, a};
    be = op == 2'b01 ? {{64{b[63]}}, b} : {64'b0, b};
    pr = ae * be;
    return op == 2'b00 ? pr[63:0] : pr[127:64];
  endfunction

  // scoreboard: every Done pops one expected result
  always @(negedge clk) begin
    if (!reset && Done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done product=%h", Product);
      end else check("product", Product, sb.pop_front());
    end
  end

  task automatic wait_lat(input bit inject, output int n, output int busy_n);
    n = 0;
    busy_n = 0;
    while (n < 300) begin
      @(negedge clk);
      if (Done) break;
      busy_n += int'(Busy);
      if (n == 0) begin
        Start = 1'b0;
        Op = 2'($urandom);
        Multiplicand = {$urandom, $urandom};
        Multiplier = {$urandom, $urandom};
      end
      if (inject && n == 10) begin
        Start = 1'b1;
        Op = 2'b11;
        Multiplicand = '1;
        Multiplier = 64'd3;
      end
      if (inject && n == 11) Start = 1'b0;
      if (inject && n == 30) check("product_held", Product, last_exp);
      n++;
    end
  endtask

  task automatic run(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                     input logic [63:0] exp, input bit inject);
    int n, busy_n;
    @(negedge clk);
    Start = 1'b1;
    Op = op;
    Multiplicand = a;
    Multiplier = b;
    sb.push_back(exp);
    wait_lat(inject, n, busy_n);
`ifdef SEQ_MULTIPLIER_EARLY_EXIT_EN
    chk_i("latency_range", int'(n >= 2 && n <= 65), 1);
`else
    chk_i("latency", n, 65);
    chk_i("busy_cycles", busy_n, 65);
`endif
    @(negedge clk);
    chk_i("done_pulse", int'(Done), 0);
    last_exp = exp;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int n, busy_n;
    logic [1:0]  rop;
    logic [63:0] ra, rb;
    tbl[0] = '{2'b00, 64'd7, 64'd6, 64'h2A};
    tbl[1] = '{2'b11, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE};
    tbl[2] = '{2'b00, '1, '1, 64'h1};
    tbl[3] = '{2'b01, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000};
    tbl[4] = '{2'b01, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 64'hFFFF_FFFF_FFFF_FFFF};
    tbl[5] = '{2'b10, '1, '1, 64'hFFFF_FFFF_FFFF_FFFF};
    tbl[6] = '{2'b10, 64'd2, 64'h8000_0000_0000_0000, 64'h1};
    tbl[7] = '{2'b00, 64'd0, 64'd12345, 64'h0};
    tbl[8] = '{2'b01, 64'd0, 64'hFFFF_FFFF_FFFF_FFF9, 64'h0};
    repeat (2) @(negedge clk);
    chk_i("reset_busy", int'(Busy), 0);
    chk_i("reset_done", int'(Done), 0);
    check("reset_product", Product, 64'h0);
    reset = 1'b0;
    for (int i = 0; i < 9; i++) run(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp, i == 3);
    for (int i = 0; i < 6; i++) begin
      rop = 2'($urandom);
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      run(rop, ra, rb, model(rop, ra, rb), 1'b0);
    end
    // Start held high: each Done cycle accepts the next pair
    @(negedge clk);
    Start = 1'b1;
    Op = 2'b00;
    Multiplicand = 64'd7;
    Multiplier = 64'd6;
    sb.push_back(64'h2A);
    for (int j = 0; j < 4; j++) begin
      n = 0;
      while (n < 300) begin
        @(negedge clk);
        if (Done) break;
        n++;
      end
`ifdef SEQ_MULTIPLIER_EARLY_EXIT_EN
      chk_i("b2b_period_range", int'(n >= 1 && n <= 65), 1);
`else
      chk_i("b2b_period", n, 65);
`endif
      if (j == 3) Start = 1'b0;
      else if (j % 2 == 0) begin
        Op = 2'b11;
        Multiplicand = '1;
        Multiplier = '1;
        sb.push_back(64'hFFFF_FFFF_FFFF_FFFE);
      end else begin
        Op = 2'b00;
        Multiplicand = 64'd7;
        Multiplier = 64'd6;
        sb.push_back(64'h2A);
      end
    end
    // reset mid-operation aborts; the aborted product must never appear
    @(negedge clk);
    Start = 1'b1;
    Op = 2'b00;
    Multiplicand = 64'd123;
    Multiplier = 64'd2;
    @(negedge clk);
    Start = 1'b0;
    repeat (9) @(negedge clk);
    Start = 1'b1;
    Op = 2'b11;
    Multiplicand = 64'd77;
    Multiplier = 64'd99;
    @(negedge clk);
    Start = 1'b0;
    repeat (19) @(negedge clk);
    #2;
    chk_i("busy_before_reset", int'(Busy), 1);
    reset = 1'b1;
    #1;
    chk_i("abort_busy", int'(Busy), 0);
    chk_i("abort_done", int'(Done), 0);
    check("abort_product", Product, 64'h0);
    Start = 1'b1;
    Op = 2'b00;
    Multiplicand = 64'd5;
    Multiplier = 64'd5;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    sb.push_back(64'h19);
    wait_lat(1'b0, n, busy_n);
`ifdef SEQ_MULTIPLIER_EARLY_EXIT_EN
    chk_i("post_reset_latency_range", int'(n >= 2 && n <= 65), 1);
    run(2'b00, 64'd12345, 64'd0, 64'h0, 1'b0);
    @(negedge clk);
    Start = 1'b1;
    Op = 2'b01;
    Multiplicand = 64'hFFFF_FFFF_FFFF_FFFF;
    Multiplier = 64'd0;
    sb.push_back(64'h0);
    wait_lat(1'b0, n, busy_n);
    chk_i("early_exit_latency", n, 2);
`else
    chk_i("post_reset_latency", n, 65);
`endif
    repeat (5) @(negedge clk);
    chk_i("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
